// File: rtl/timer_set_ctrl.sv
// Time-set controller: sequences day/hour/min/sec editing, gates the BCD counter chain and loads the edited time.
// Optional macro TIMER_SET_AUTOEXIT_EN adds an idle timeout that drops back to RUN without loading.
`timescale 1ns/1ps
module timer_set_ctrl #(
    parameter int BLINK_DIV   = 25_000_000,
    parameter int TIMEOUT_CYC = 500_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [3:0] cur_day,
    input  logic [3:0] cur_hour_h,
    input  logic [3:0] cur_hour_l,
    input  logic [3:0] cur_min_h,
    input  logic [3:0] cur_min_l,
    input  logic [3:0] cur_sec_h,
    input  logic [3:0] cur_sec_l,
    output logic       run_en,
    output logic       load,
    output logic [3:0] ld_day,
    output logic [3:0] ld_hour_h,
    output logic [3:0] ld_hour_l,
    output logic [3:0] ld_min_h,
    output logic [3:0] ld_min_l,
    output logic [3:0] ld_sec_h,
    output logic [3:0] ld_sec_l,
    output logic [3:0] field_sel,
    output logic       blink
);

    typedef enum logic [2:0] {RUN, SET_DAY, SET_HOUR, SET_MIN, SET_SEC, APPLY} state_t;

    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    state_t state, next_state;
    logic [BW-1:0] blink_cnt;
    logic [3:0] e_day;
    logic [7:0] e_hour, e_min, e_sec;
    logic any_btn, edit_ev, idle_exp;

    function automatic logic is_set(input state_t s);
        return (s == SET_DAY) || (s == SET_HOUR) || (s == SET_MIN) || (s == SET_SEC);
    endfunction

    function automatic logic [3:0] sel_of(input state_t s);
        case (s)
            SET_DAY:  return 4'b1000;
            SET_HOUR: return 4'b0100;
            SET_MIN:  return 4'b0010;
            SET_SEC:  return 4'b0001;
            default:  return 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] day_step(input logic [3:0] v, input logic up);
        if (up)
            return (v >= 4'd9) ? 4'd0 : v + 4'd1;
        return (v == 4'd0) ? 4'd9 : v - 4'd1;
    endfunction

    // Two-digit BCD step with wrap at 00 / top (top is BCD, e.g. 8'h23 or 8'h59).
    function automatic logic [7:0] pair_step(input logic [7:0] v, input logic up, input logic [7:0] top);
        if (up) begin
            if (v == top)          return 8'h00;
            if (v[3:0] == 4'd9)    return {v[7:4] + 4'd1, 4'd0};
            return {v[7:4], v[3:0] + 4'd1};
        end
        if (v == 8'h00)            return top;
        if (v[3:0] == 4'd0)        return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    // With a legal low digit, raw byte compare matches numeric BCD order.
    function automatic logic [7:0] pair_clamp(input logic [7:0] v, input logic [7:0] top);
        return (v[3:0] <= 4'd9 && v <= top) ? v : 8'h00;
    endfunction

    assign any_btn = btn_mode | btn_inc | btn_dec;
    assign edit_ev = is_set(state) & ~btn_mode & (btn_inc | btn_dec);

`ifdef TIMER_SET_AUTOEXIT_EN
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0] idle_cnt;

    assign idle_exp = is_set(state) && !any_btn && (idle_cnt == IDLE_LAST);

    always_ff @(posedge clk) begin
        if (rst)
            idle_cnt <= '0;
        else if (!is_set(next_state) || next_state != state || any_btn)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + TW'(1);
    end
`else
    assign idle_exp = 1'b0;
`endif

    always_comb begin
        next_state = state;
        case (state)
            RUN:      if (btn_mode) next_state = SET_DAY;
            SET_DAY:  if (btn_mode) next_state = SET_HOUR;
            SET_HOUR: if (btn_mode) next_state = SET_MIN;
            SET_MIN:  if (btn_mode) next_state = SET_SEC;
            SET_SEC:  if (btn_mode) next_state = APPLY;
            APPLY:    next_state = RUN;
            default:  next_state = RUN;
        endcase
        if (idle_exp)
            next_state = RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            run_en    <= 1'b0;
            load      <= 1'b0;
            field_sel <= 4'b0000;
            blink     <= 1'b0;
            blink_cnt <= '0;
        end else begin
            state     <= next_state;
            run_en    <= (next_state == RUN);
            load      <= (next_state == APPLY);
            field_sel <= sel_of(next_state);
            if (!is_set(next_state) || next_state != state || edit_ev) begin
                blink_cnt <= '0;
                blink     <= 1'b0;
            end else if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink     <= ~blink;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_day  <= 4'd0;
            e_hour <= 8'h00;
            e_min  <= 8'h00;
            e_sec  <= 8'h00;
        end else if (state == RUN && btn_mode) begin
            e_day  <= (cur_day <= 4'd9) ? cur_day : 4'd0;
            e_hour <= pair_clamp({cur_hour_h, cur_hour_l}, 8'h23);
            e_min  <= pair_clamp({cur_min_h, cur_min_l}, 8'h59);
            e_sec  <= pair_clamp({cur_sec_h, cur_sec_l}, 8'h59);
        end else if (edit_ev && (btn_inc ^ btn_dec)) begin
            case (state)
                SET_DAY:  e_day  <= day_step(e_day, btn_inc);
                SET_HOUR: e_hour <= pair_step(e_hour, btn_inc, 8'h23);
                SET_MIN:  e_min  <= pair_step(e_min, btn_inc, 8'h59);
                SET_SEC:  e_sec  <= pair_step(e_sec, btn_inc, 8'h59);
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_day    <= 4'd0;
            ld_hour_h <= 4'd0;
            ld_hour_l <= 4'd0;
            ld_min_h  <= 4'd0;
            ld_min_l  <= 4'd0;
            ld_sec_h  <= 4'd0;
            ld_sec_l  <= 4'd0;
        end else if (next_state == APPLY) begin
            ld_day                 <= e_day;
            {ld_hour_h, ld_hour_l} <= e_hour;
            {ld_min_h, ld_min_l}   <= e_min;
            {ld_sec_h, ld_sec_l}   <= e_sec;
        end
    end

endmodule
